// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: turns RV32 load/store requests from the core into single-beat
// start/busy commands for the AXI4-Lite master. It builds store lanes and strobes
// and extracts and extends load lanes. It rejects misaligned or illegal accesses
// locally, and it stalls the core until the access completes.
// Optional feature: define LSU_AXI_TIMEOUT_EN to enable a bus watchdog that ends
// a stuck transaction with mem_bus_err after TIMEOUT_CYCLES wait cycles.
module lsu_axi_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req_read,
   input  logic                  mem_req_write,
   input  logic [2:0]            mem_funct3,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_stall,
   output logic                  mem_done,
   output logic                  mem_misaligned,
   output logic                  mem_bus_err,
   output logic                  write_start,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [3:0]            write_strobe,
   input  logic                  write_busy,
   output logic                  read_start,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic                  read_busy,
   input  logic [DATA_WIDTH-1:0] read_data
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CHECK   = 3'd1;
   localparam logic [2:0] ST_START   = 3'd2;
   localparam logic [2:0] ST_WAIT_HI = 3'd3;
   localparam logic [2:0] ST_WAIT_LO = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   // Returns 1 when the access is misaligned for its size or uses an undefined funct3.
   function automatic logic access_bad(input logic is_wr, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (is_wr) begin
         case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = off[0];
            3'b010:  bad = (off != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off != 2'b00);
            default:        bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   // Byte strobe for a store of the given size at the given byte offset.
   function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] strb;
      case (f3)
         3'b000:  strb = 4'b0001 << off;
         3'b001:  strb = 4'b0011 << {off[1], 1'b0};
         3'b010:  strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Replicates right-justified store data across every lane it could occupy.
   function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] wd);
      logic [DATA_WIDTH-1:0] d;
      case (f3)
         3'b000:  d = {4{wd[7:0]}};
         3'b001:  d = {2{wd[15:0]}};
         3'b010:  d = wd;
         default: d = {DATA_WIDTH{1'b0}};
      endcase
      return d;
   endfunction

   // Moves the addressed lane to bit 0 and sign- or zero-extends it.
   function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                         input logic [1:0] off,
                                                         input logic [DATA_WIDTH-1:0] rd);
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] r;
      sh = rd >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b010:  r = sh;
         3'b100:  r = {24'd0, sh[7:0]};
         3'b101:  r = {16'd0, sh[15:0]};
         default: r = {DATA_WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   logic [2:0]            state_r;
   logic [2:0]            next_state_s;
   logic                  is_write_r;
   logic [2:0]            funct3_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic                  busy_s;
   logic                  bad_s;
   logic                  timeout_s;
   logic                  finish_ok_s;
   logic                  finish_err_s;
   logic [ADDR_WIDTH-1:0] aligned_s;

   assign busy_s    = is_write_r ? write_busy : read_busy;
   assign bad_s     = access_bad(is_write_r, funct3_r, addr_r[1:0]);
   assign aligned_s = {addr_r[ADDR_WIDTH-1:2], 2'b00};
   assign mem_stall = (mem_req_read | mem_req_write) & (state_r != ST_DONE);

`ifdef LSU_AXI_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt_r;

   // Watchdog: cleared when a command is issued, counts every cycle spent waiting on busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_START) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO)) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
      end
   end

   assign timeout_s = (tmo_cnt_r >= CNT_W'(TIMEOUT_CYCLES));
`else
   localparam logic [31:0] TMO_UNUSED = 32'(TIMEOUT_CYCLES);
   logic unused_tmo_s;
   assign unused_tmo_s = ^TMO_UNUSED;
   assign timeout_s    = 1'b0;
`endif

   // Next-state decode and completion qualifiers for the wait states.
   always_comb begin
      next_state_s = state_r;
      finish_ok_s  = 1'b0;
      finish_err_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (mem_req_write || mem_req_read) begin
               next_state_s = ST_CHECK;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (bad_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_START;
            end
         end
         ST_START: next_state_s = ST_WAIT_HI;
         ST_WAIT_HI: begin
            if (busy_s) begin
               next_state_s = ST_WAIT_LO;
            end else if (timeout_s) begin
               next_state_s = ST_DONE;
               finish_err_s = 1'b1;
            end else begin
               next_state_s = ST_WAIT_HI;
            end
         end
         ST_WAIT_LO: begin
            if (!busy_s) begin
               next_state_s = ST_DONE;
               finish_ok_s  = 1'b1;
            end else if (timeout_s) begin
               next_state_s = ST_DONE;
               finish_err_s = 1'b1;
            end else begin
               next_state_s = ST_WAIT_LO;
            end
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register, request latch and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         is_write_r     <= 1'b0;
         funct3_r       <= 3'b000;
         addr_r         <= {ADDR_WIDTH{1'b0}};
         wdata_r        <= {DATA_WIDTH{1'b0}};
         mem_rdata      <= {DATA_WIDTH{1'b0}};
         mem_done       <= 1'b0;
         mem_misaligned <= 1'b0;
         mem_bus_err    <= 1'b0;
         write_start    <= 1'b0;
         write_addr     <= {ADDR_WIDTH{1'b0}};
         write_data     <= {DATA_WIDTH{1'b0}};
         write_strobe   <= 4'b0000;
         read_start     <= 1'b0;
         read_addr      <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_r        <= next_state_s;
         write_start    <= 1'b0;
         read_start     <= 1'b0;
         mem_done       <= 1'b0;
         mem_misaligned <= 1'b0;
         mem_bus_err    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (mem_req_write || mem_req_read) begin
                  is_write_r <= mem_req_write;
                  funct3_r   <= mem_funct3;
                  addr_r     <= mem_addr;
                  wdata_r    <= mem_wdata;
               end
            end
            ST_CHECK: begin
               if (bad_s) begin
                  mem_done       <= 1'b1;
                  mem_misaligned <= 1'b1;
                  mem_rdata      <= {DATA_WIDTH{1'b0}};
               end else if (is_write_r) begin
                  write_start  <= 1'b1;
                  write_addr   <= aligned_s;
                  write_data   <= lane_data(funct3_r, wdata_r);
                  write_strobe <= lane_strobe(funct3_r, addr_r[1:0]);
               end else begin
                  read_start <= 1'b1;
                  read_addr  <= aligned_s;
               end
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
               if (finish_ok_s) begin
                  mem_done  <= 1'b1;
                  mem_rdata <= is_write_r ? {DATA_WIDTH{1'b0}}
                                          : load_extend(funct3_r, addr_r[1:0], read_data);
               end else if (finish_err_s) begin
                  mem_done    <= 1'b1;
                  mem_bus_err <= 1'b1;
                  mem_rdata   <= {DATA_WIDTH{1'b0}};
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_axi_bridge.md
Name: lsu_axi_bridge

Overview:
- Sits between the RV32IM core's load/store stage and the axi4_lite_master's start/busy command interface.
- Converts core memory requests into single-beat master commands.
- Store side: aligns the address to a word, builds the byte strobe and replicates write data across lanes.
- Load side: extracts the addressed lanes from read data and sign- or zero-extends them.
- Stalls the core until the master transaction completes.
- Misaligned or illegal accesses are rejected locally and never reach the bus.

Parameters:
- ADDR_WIDTH, 32, address width on both core and master sides.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, watchdog limit used only when LSU_AXI_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- mem_req_read  in  1  core load request; held until mem_done
- mem_req_write  in  1  core store request; held until mem_done
- mem_funct3  in  3  RV32 load/store funct3
- mem_addr  in  ADDR_WIDTH  byte address
- mem_wdata  in  DATA_WIDTH  store data, right-justified
- mem_rdata  out  DATA_WIDTH  extended load result, valid while mem_done=1
- mem_stall  out  1  core stall request
- mem_done  out  1  one-cycle completion pulse
- mem_misaligned  out  1  one-cycle pulse with mem_done on a rejected access
- mem_bus_err  out  1  one-cycle pulse with mem_done on timeout
- write_start, read_start  out  1  one-cycle command pulses to the master
- write_addr, read_addr  out  ADDR_WIDTH  word-aligned address, {addr[31:2],2'b00}
- write_data  out  DATA_WIDTH  lane-replicated store data
- write_strobe  out  4  byte strobe
- write_busy, read_busy  in  1  master busy flags
- read_data  in  DATA_WIDTH  master read result

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: starts, addr, data, strobe, done, misaligned, bus_err, rdata.
  - An in-flight transaction is abandoned; the master shares the reset.
- Master contract:
  - busy rises the cycle after start and stays high at least 1 cycle.
  - read_data is valid from the first cycle busy is low again.
- States: IDLE, CHECK, START, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - If mem_req_write or mem_req_read is high: latch addr, funct3, wdata and direction; go to CHECK.
  - Write has priority when both requests are high; the read is ignored.
- CHECK, legality rules:
  - Half-word access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Load funct3 ∈ {011,110,111} is illegal.
  - Store funct3 >010 is illegal.
  - Misaligned or illegal: go to DONE with mem_misaligned=1 and mem_rdata=0; no start is issued.
  - Otherwise go to START.
- START:
  - Drive write_start or read_start high for exactly 1 cycle with address, data and strobe stable.
  - Address, data and strobe outputs hold until DONE.
  - Then go to WAIT_HI.
- WAIT_HI: wait for busy=1, then go to WAIT_LO.
- WAIT_LO: wait for busy=0, capture and extend read_data, then go to DONE.
- DONE:
  - mem_done=1 for 1 cycle, then go to IDLE.
  - The core must drop or replace its request in this cycle.
- mem_stall = (mem_req_read | mem_req_write) & (state≠DONE). It is combinational, so it is high in IDLE the same cycle a request appears.
- Store lanes:
  - SB: strobe=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: strobe=4'b0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}.
  - SW: strobe=4'b1111, data=wdata.
- Load extraction:
  - Shift read_data right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency: a legal access with a minimal 1-cycle busy takes 5 cycles from request to mem_done; a rejected access takes 2 cycles.
- Back-to-back requests: a new request is accepted in IDLE the cycle after DONE.

Optional Feature:
- Macro: LSU_AXI_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on START and increments in WAIT_HI/WAIT_LO.
  - When it reaches TIMEOUT_CYCLES: go to DONE with mem_bus_err=1 and mem_rdata=0.
- Not defined: no counter; WAIT states wait indefinitely; mem_bus_err is tied to 0.

Test Plan:
- SW addr 0x04, data 0xAABBCCDD -> write_addr=0x04, strobe=1111, write_data=0xAABBCCDD, single write_start, mem_done 1 cycle after busy falls.
- SB addr 0x07, wdata 0x000000EE -> write_addr=0x04, strobe=1000, write_data=0xEEEEEEEE.
- Memory word 0xAABBCCDD at 0x04: LB 0x05 -> 0xFFFFFFCC; LBU 0x05 -> 0x000000CC; LH 0x06 -> 0xFFFFAABB; LW 0x04 -> 0xAABBCCDD.
- LW addr 0x06 or SH addr 0x03 -> no start pulse, mem_misaligned=1 with mem_done, stall released after 2 cycles.
- Slave forced non-responding with LSU_AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16 -> mem_bus_err=1 with mem_done about 16 cycles after START, then IDLE.
- rst=0 asserted in WAIT_LO mid-read -> next cycle all outputs 0 and state IDLE; a subsequent LW 0x04 completes correctly.
